// File: rtl/dram_bus_pkg.sv
// Shared bus constants and responder state encoding, used by the DRAM responder
// and by the cache side of the bus.
package dram_bus_pkg;

  localparam int BUS_DATA_W       = 64;
  localparam int BUS_TAG_W        = 13;
  localparam int BEATS_PER_LINE   = 8;
  localparam int BEAT_BITS        = $clog2(BEATS_PER_LINE);
  localparam int LINE_OFFSET_BITS = 6;
  localparam int TAG_RW_BIT       = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACK    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RESP   = 3'd3,
    ST_WRDATA = 3'd4
  } dram_state_e;

endpackage

// File: rtl/dram_resp_store.sv
// Backing store for the DRAM responder: one synchronous write port and one
// asynchronous read port. Contents are not touched by reset.
module dram_resp_store
  import dram_bus_pkg::*;
#(
  parameter int WORDS  = 2048,
  parameter int DATA_W = BUS_DATA_W,
  parameter int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dram_responder.sv
// Line-burst DRAM responder: 8-beat reads and writes against a local store.
// Define DRAM_RESPONDER_LATENCY_EN to insert READ_LATENCY wait cycles before read data.
module dram_responder
  import dram_bus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = BUS_DATA_W,
  parameter int BUS_TAG_WIDTH  = BUS_TAG_W,
  parameter int MEM_WORDS      = 2048,
  parameter int READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_bus_reqcyc,
  output logic                      m_bus_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  output logic                      m_bus_respcyc,
  input  logic                      m_bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  output dram_state_e               dbg_state
);

  // Handshake: a request or write beat transfers in a cycle where reqcyc and
  // reqack are both high; a read beat transfers where respcyc and respack are
  // both high, and respcyc/resp/resptag hold steady until that happens.

  localparam int ADDR_W     = $clog2(MEM_WORDS);
  localparam int LINE_IDX_W = ADDR_W - BEAT_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS_PER_LINE - 1);

  dram_state_e             state_q, state_d;
  logic [LINE_IDX_W-1:0]   line_q, line_d;
  logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
  logic [BEAT_BITS-1:0]    beat_q, beat_d;
  logic                    wr_en;
  logic [ADDR_W-1:0]       word_idx;
  logic [BUS_DATA_WIDTH-1:0] rd_data;

`ifdef DRAM_RESPONDER_LATENCY_EN
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CNT_LOAD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_read_latency;
  assign unused_read_latency = (READ_LATENCY != 0);
`endif

  // Only the line bits that survive the modulo-MEM_WORDS wrap are kept.
  assign word_idx = {line_q, beat_q};

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    tag_d        = tag_q;
    beat_d       = beat_q;
    wr_en        = 1'b0;
    m_bus_reqack = 1'b0;
`ifdef DRAM_RESPONDER_LATENCY_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (m_bus_reqcyc) begin
          line_d  = m_bus_req[LINE_OFFSET_BITS +: LINE_IDX_W];
          tag_d   = m_bus_reqtag;
          beat_d  = '0;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        m_bus_reqack = 1'b1;
        if (!tag_q[TAG_RW_BIT]) begin
          state_d = ST_WRDATA;
        end else begin
`ifdef DRAM_RESPONDER_LATENCY_EN
          if (READ_LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(CNT_LOAD);
          end
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef DRAM_RESPONDER_LATENCY_EN
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      ST_RESP: begin
        if (m_bus_respack) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WRDATA: begin
        m_bus_reqack = m_bus_reqcyc;
        if (m_bus_reqcyc) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      tag_q   <= '0;
      beat_q  <= '0;
`ifdef DRAM_RESPONDER_LATENCY_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      tag_q   <= tag_d;
      beat_q  <= beat_d;
`ifdef DRAM_RESPONDER_LATENCY_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  dram_resp_store #(
    .WORDS  (MEM_WORDS),
    .DATA_W (BUS_DATA_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (word_idx),
    .wr_data (m_bus_req),
    .rd_addr (word_idx),
    .rd_data (rd_data)
  );

  // Read outputs are forced to zero outside RESP so reset and idle read back as zero.
  assign m_bus_respcyc = (state_q == ST_RESP);
  assign m_bus_resp    = m_bus_respcyc ? rd_data : '0;
  assign m_bus_resptag = m_bus_respcyc ? tag_q : '0;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: table-driven read vectors, hand-written
// corner sequences and randomized bursts against a word-array reference model.
module tb_dram_responder;
  import dram_bus_pkg::*;

  localparam int DW           = 64;
  localparam int TW           = 13;
  localparam int MEM_WORDS    = 2048;
  localparam int READ_LATENCY = 4;
`ifdef DRAM_RESPONDER_LATENCY_EN
  localparam int EXP_WAIT = READ_LATENCY;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m_bus_reqcyc;
  logic          m_bus_reqack;
  logic [DW-1:0] m_bus_req;
  logic [TW-1:0] m_bus_reqtag;
  logic          m_bus_respcyc;
  logic          m_bus_respack;
  logic [DW-1:0] m_bus_resp;
  logic [TW-1:0] m_bus_resptag;
  dram_state_e   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]   model_mem [int];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [63:0] addr;
    logic [12:0] tag;
    int          stall_beat;
    int          stall_len;
    logic [63:0] exp0;
    logic [63:0] exp7;
  } rd_vec_t;

  rd_vec_t vecs[5];

  dram_responder #(
    .BUS_DATA_WIDTH (DW),
    .BUS_TAG_WIDTH  (TW),
    .MEM_WORDS      (MEM_WORDS),
    .READ_LATENCY   (READ_LATENCY)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word index straight from the addressing rule: line number * 8 + beat, mod depth.
  function automatic int midx(input logic [63:0] a, input int b);
    longint unsigned w;
    w = ((a >> 6) << 3) + longint'(b);
    return int'(w % longint'(MEM_WORDS));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                          input logic [63:0] d [8], input int nbeats, input bit gaps);
    m_bus_reqcyc = 1'b1;
    m_bus_req    = addr;
    m_bus_reqtag = tag;
    @(negedge clk);
    check("wr_idle_noack", m_bus_reqack, 0);
    tick();
    // ACK cycle: junk on the bus must be neither acked as data nor stored
    m_bus_reqcyc = 1'($urandom_range(0, 1));
    m_bus_req    = {$urandom, $urandom};
    @(negedge clk);
    check("wr_ack", m_bus_reqack, 1);
    check("wr_ack_norespcyc", m_bus_respcyc, 0);
    tick();
    for (int b = 0; b < nbeats; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        m_bus_reqcyc = 1'b0;
        @(negedge clk);
        check("wr_gap_noack", m_bus_reqack, 0);
        tick();
      end
      m_bus_reqcyc = 1'b1;
      m_bus_req    = d[b];
      @(negedge clk);
      check("wr_beat_ack", m_bus_reqack, 1);
      tick();
      model_mem[midx(addr, b)] = d[b];
    end
    m_bus_reqcyc = 1'b0;
    if (nbeats == 8) begin
      @(negedge clk);
      check("wr_done_noack", m_bus_reqack, 0);
      check("wr_done_idle", 64'(dbg_state), 64'(ST_IDLE));
      tick();
    end else begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("abort_reqack", m_bus_reqack, 0);
      check("abort_respcyc", m_bus_respcyc, 0);
      check("abort_resp", m_bus_resp, 0);
      check("abort_resptag", m_bus_resptag, 0);
      check("abort_idle", 64'(dbg_state), 64'(ST_IDLE));
      tick();
    end
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                         input int stall_beat, input int stall_len, input bit rand_stall,
                         input bit hold, input logic [63:0] addr2, input logic [12:0] tag2,
                         input bit skip_req,
                         output logic [63:0] got0, output logic [63:0] got7);
    int  k;
    int  nstall;
    bit  timed_out;
    logic [63:0] exp;
    got0 = '0;
    got7 = '0;
    for (int b = 0; b < 8; b++) begin
      exp_q.push_back(model_mem.exists(midx(addr, b)) ? model_mem[midx(addr, b)] : 64'h0);
    end
    if (!skip_req) begin
      m_bus_reqcyc = 1'b1;
      m_bus_req    = addr;
      m_bus_reqtag = tag;
      @(negedge clk);
      check("rd_idle_noack", m_bus_reqack, 0);
      tick();
    end
    if (hold) begin
      m_bus_reqcyc = 1'b1;
      m_bus_req    = addr2;
      m_bus_reqtag = tag2;
    end else begin
      m_bus_reqcyc = 1'b0;
      m_bus_req    = {$urandom, $urandom};
    end
    k = 1;
    timed_out = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      check("rd_reqack", m_bus_reqack, (k == 1) ? 64'd1 : 64'd0);
      if (m_bus_respcyc) begin
        timed_out = 1'b0;
        break;
      end
      tick();
      k++;
    end
    if (timed_out) begin
      check("rd_timeout", 0, 1);
      exp_q.delete();
      m_bus_reqcyc = 1'b0;
      return;
    end
    check("rd_latency", 64'(k), 64'(2 + EXP_WAIT));
    for (int b = 0; b < 8; b++) begin
      exp = exp_q.pop_front();
      if (b == stall_beat) nstall = stall_len;
      else if (rand_stall) nstall = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      else nstall = 0;
      for (int s = 0; s <= nstall; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        check("rd_respcyc", m_bus_respcyc, 1);
        check("rd_data", m_bus_resp, exp);
        check("rd_tag", m_bus_resptag, tag);
        check("rd_noreqack", m_bus_reqack, 0);
        if (b == 0) got0 = m_bus_resp;
        if (b == 7) got7 = m_bus_resp;
        m_bus_respack = (s == nstall);
        tick();
      end
    end
    m_bus_respack = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("rd_end_respcyc", m_bus_respcyc, 0);
    check("rd_end_resp", m_bus_resp, 0);
    check("rd_end_noreqack", m_bus_reqack, 0);
    tick();
  endtask

  // ---------------- test sequence ----------------
  logic [63:0] d [8];
  logic [63:0] g0, g7;
  logic [63:0] lines [6];

  initial begin
    reset         = 1'b1;
    m_bus_reqcyc  = 1'b0;
    m_bus_req     = '0;
    m_bus_reqtag  = '0;
    m_bus_respack = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_reqack", m_bus_reqack, 0);
    check("rst_respcyc", m_bus_respcyc, 0);
    check("rst_resp", m_bus_resp, 0);
    check("rst_resptag", m_bus_resptag, 0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Write line 0x1000 with 0x11..0x88
    for (int b = 0; b < 8; b++) d[b] = 64'h11 * 64'(b + 1);
    do_write(64'h1000, 13'h0005, d, 8, 1'b0);

    vecs[0] = '{64'h1000,                  13'h1005, -1, 0, 64'h11, 64'h88};
    vecs[1] = '{64'h1000,                  13'h1005,  2, 3, 64'h11, 64'h88};
    vecs[2] = '{64'h1000_0000_0000_1000,   13'h1ABC, -1, 0, 64'h11, 64'h88};
    vecs[3] = '{64'h1027,                  13'h1005,  5, 1, 64'h11, 64'h88};
    vecs[4] = '{64'h1000,                  13'h1FFF,  7, 2, 64'h11, 64'h88};
    for (int i = 0; i < 5; i++) begin
      do_read(vecs[i].addr, vecs[i].tag, vecs[i].stall_beat, vecs[i].stall_len, 1'b0,
              1'b0, 64'h0, 13'h0, 1'b0, g0, g7);
      check("vec_beat0", g0, vecs[i].exp0);
      check("vec_beat7", g7, vecs[i].exp7);
    end

    // reqcyc held high through a read: next request only taken after IDLE
    for (int b = 0; b < 8; b++) d[b] = 64'hC0DE_0000 + 64'(b);
    do_write(64'h1040, 13'h0FFF, d, 8, 1'b1);
    do_read(64'h1000, 13'h1005, 3, 2, 1'b0, 1'b1, 64'h1040, 13'h1077, 1'b0, g0, g7);
    check("hold_first_beat0", g0, 64'h11);
    do_read(64'h1040, 13'h1077, -1, 0, 1'b0, 1'b0, 64'h0, 13'h0, 1'b1, g0, g7);
    check("hold_second_beat0", g0, 64'hC0DE_0000);
    check("hold_second_beat7", g7, 64'hC0DE_0007);

    // Reset during a write burst: beats 0-3 new, 4-7 old
    for (int b = 0; b < 8; b++) d[b] = 64'hA0 + 64'(b);
    do_write(64'h2000, 13'h0001, d, 8, 1'b0);
    for (int b = 0; b < 8; b++) d[b] = 64'hB0 + 64'(b);
    do_write(64'h2000, 13'h0002, d, 4, 1'b0);
    do_read(64'h2000, 13'h1002, -1, 0, 1'b0, 1'b0, 64'h0, 13'h0, 1'b0, g0, g7);
    check("abort_rd_beat0_new", g0, 64'hB0);
    check("abort_rd_beat7_old", g7, 64'hA7);

    // Randomized traffic over a few lines, some with high address bits set
    for (int l = 0; l < 6; l++) begin
      lines[l] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
      do_write(lines[l], 13'($urandom) & 13'h0FFF, d, 8, 1'b1);
    end
    for (int t = 0; t < 24; t++) begin
      int l;
      l = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 8; b++) d[b] = {$urandom, $urandom};
        do_write(lines[l], 13'($urandom) & 13'h0FFF, d, 8, 1'b1);
      end else begin
        do_read(lines[l], 13'($urandom) | 13'h1000, -1, 0, 1'b1, 1'b0, 64'h0, 13'h0,
                1'b0, g0, g7);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus word width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, request tag width; tag bit 12 = 1 read, 0 write.
REQ-003 SHALL have parameter MEM_WORDS, default 2048, backing-store depth in 64-bit words (power of 2).
REQ-004 SHALL have parameter READ_LATENCY, default 4, wait cycles from address ack to first read beat.
REQ-005 clk  in  1  clock; all state changes on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 m_bus_reqcyc  in  1  request/write-data valid from initiator.
REQ-008 m_bus_reqack  out  1  request or write-beat accepted.
REQ-009 m_bus_req  in  64  line address, or write data during a write burst.
REQ-010 m_bus_reqtag  in  13  request tag.
REQ-011 m_bus_respcyc  out  1  read beat valid.
REQ-012 m_bus_respack  in  1  initiator accepts current read beat.
REQ-013 m_bus_resp  out  64  read beat data.
REQ-014 m_bus_resptag  out  13  tag of the request being answered.

Function
REQ-015 SHALL implement the states IDLE, ACK, WAIT, RESP, WRDATA.
REQ-016 IDLE: reqack=0, respcyc=0; on reqcyc=1, SHALL latch req as address and reqtag, clear beat counter, go to ACK.
REQ-017 ACK: SHALL drive reqack=1 for exactly one cycle; next WRDATA if latched tag[12]=0, else WAIT (or RESP, per REQ-028/029).
REQ-018 Word index SHALL be {addr[63:6], beat[2:0]} modulo MEM_WORDS; addr[5:0] ignored; upper bits wrap silently.
REQ-019 RESP: respcyc=1, resp=mem[index], resptag=latched tag; when respack=1 in the same cycle SHALL increment beat, else hold all outputs stable.
REQ-020 RESP with beat=7 and respack=1 SHALL go to IDLE; respcyc low the next cycle.
REQ-021 Beat 0 SHALL carry line bits [63:0], beat 7 bits [511:448].
REQ-022 WRDATA: reqack SHALL equal reqcyc combinationally; on reqcyc=1, mem[index] <= req and beat increments; beat=7 accepted -> IDLE.
REQ-023 reqcyc in ACK, WAIT or RESP SHALL be ignored (no ack, no latch).
REQ-024 A new request SHALL be accepted no earlier than the cycle after return to IDLE; back-to-back bursts cost one idle cycle.
REQ-025 Minimum read latency: reqcyc sample -> first respcyc = 2 + wait cycles; write burst completes in ACK + 8 accepted beats.

Reset
REQ-026 On reset: state IDLE, reqack=0, respcyc=0, resp=0, resptag=0, beat=0, wait counter=0; in-flight burst abandoned.
REQ-027 Backing store SHALL NOT be cleared by reset; words already written in an abandoned burst stay written; store is zero at time zero.

Configuration
REQ-028 With DRAM_RESPONDER_LATENCY_EN defined: read path ACK -> WAIT, counter loads READ_LATENCY-1, RESP after READ_LATENCY WAIT cycles; READ_LATENCY=0 skips WAIT.
REQ-029 Without DRAM_RESPONDER_LATENCY_EN: WAIT state and counter absent, ACK -> RESP directly, READ_LATENCY ignored.

Structure
REQ-030 Shared package dram_bus_pkg SHALL hold: state enum, BEATS_PER_LINE=8, LINE_OFFSET_BITS=6, TAG_RW_BIT=12, bus width constants; cache side reuses it.
REQ-031 Backing store SHALL be sub-module dram_resp_store: one write port, one async read port, MEM_WORDS x 64; control FSM stays in dram_responder.

Verification
REQ-032 Write burst addr 0x1000 tag 0x0005, data 0x11..0x88 (beats 0-7) -> reqack once in ACK, reqack on each of 8 beats, back to IDLE.
REQ-033 Read addr 0x1000 tag 0x1005, respack always 1, latency 4 -> respcyc 2+4 cycles after request, beats 0x11..0x88 in order, resptag 0x1005.
REQ-034 Read with respack held low 3 cycles on beat 2 -> resp/resptag stable for those cycles, no beat skipped or repeated.
REQ-035 Read addr 0x1000_0000_0000_1000 (wraps, MEM_WORDS=2048) -> same data as 0x1000; addr 0x1027 -> same data as 0x1000.
REQ-036 reqcyc held 1 during RESP of prior read -> no reqack until IDLE; new request then acked.
REQ-037 reset asserted after beat 3 of write to 0x2000 -> outputs zero next cycle, IDLE; later read 0x2000 returns beats 0-3 new, 4-7 old.
